// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants, state encoding and digit helpers for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned BCD_MAX    = 9;
  localparam int unsigned ADJ_THRESH = 8;
  localparam int unsigned ADJ_SUB    = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic logic digit_valid(logic [BCD_W-1:0] d);
    return d <= 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One-digit correction step of reverse double-dabble: fields that reached 8 after a right
// shift carried a half-ten in from the digit above, so take 3 back off.
module bcd_digit_adj
  import bcd2bin_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'(ADJ_THRESH)) begin
      digit_o = digit_i - 4'(ADJ_SUB);
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock) with a
// start/done handshake; invalid digits finish immediately with err set.
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int unsigned NDIG  = 2,
  parameter int unsigned OUT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*NDIG-1:0]   bcd_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [OUT_W-1:0]    bin_out
);

  localparam int unsigned DigW = BCD_W * NDIG;
  localparam int unsigned SrW  = 2 * DigW;
  localparam int unsigned CntW = $clog2(DigW + 1);

  state_e            state_q, state_d;
  logic [SrW-1:0]    sr_q, sr_d, sr_shift, sr_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              bcd_ok;

  // BCD digits live in the upper half; the binary result fills the lower half from the top.
  assign sr_shift = sr_q >> 1;
  assign sr_adj[DigW-1:0] = sr_shift[DigW-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (sr_shift[DigW + BCD_W*g +: BCD_W]),
      .digit_o (sr_adj[DigW + BCD_W*g +: BCD_W])
    );
  end

  always_comb begin
    bcd_ok = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!digit_valid(bcd_in[BCD_W*i +: BCD_W])) begin
        bcd_ok = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (bcd_ok) begin
            state_d = StShift;
            sr_d    = {bcd_in, {DigW{1'b0}}};
            cnt_d   = '0;
          end else begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end
      end
      StShift: begin
        sr_d  = sr_adj;
        cnt_d = cnt_q + 1'b1;
        // Final shift: publish straight from the shifted value so bin_out skips partials.
        if (cnt_q == CntW'(DigW - 1)) begin
          state_d = StDone;
          bin_d   = OUT_W'(sr_adj[DigW-1:0]);
          err_d   = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule
